// File: rtl/cam_tx_axis_if.sv
// rtl/cam_tx_axis_if.sv - AXI4-Stream pixel bus feeding the CameraLink transmitter
interface cam_tx_axis_if #(
  parameter int DATA_WIDTH = 24,
  parameter int USER_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;

  modport master (output tdata, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/cam_tx_axis.sv
// rtl/cam_tx_axis.sv - AXI4-Stream RGB video to CameraLink base-configuration word generator
// Frame/line blanking, stall padding with DVAL low, and abort on an unexpected start of frame.
module cam_tx_axis #(
  parameter int DATA_WIDTH = 24,
  parameter int USER_WIDTH = 1,
  parameter int LINES      = 1024,
  parameter int HBLANK     = 16,
  parameter int VBLANK     = 64,
  parameter int FV_LEAD    = 4,
  parameter int FV_TRAIL   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 cam_clk,
  input  logic                 rst,
  cam_tx_axis_if.slave         s_axis,
  output logic [27:0]          cam_data_out,
  output logic                 underrun,
  output logic                 sof_early,
  output logic [CNT_WIDTH-1:0] frame_cnt
);

  typedef enum logic [2:0] {
    ST_WAIT_SOF,
    ST_FV_LEAD,
    ST_LINE_WAIT,
    ST_LINE,
    ST_HBLANK,
    ST_FV_TRAIL,
    ST_VBLANK
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LEAD_END  = CNT_WIDTH'(FV_LEAD - 1);
  localparam logic [CNT_WIDTH-1:0] HB_END    = CNT_WIDTH'(HBLANK - 1);
  localparam logic [CNT_WIDTH-1:0] TRAIL_END = CNT_WIDTH'(FV_TRAIL - 1);
  localparam logic [CNT_WIDTH-1:0] VB_END    = CNT_WIDTH'(VBLANK - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_LINE = CNT_WIDTH'(LINES - 1);

  state_t               state, state_d;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] line_cnt;
  logic                 tready_c;
  logic                 beat;
  logic                 sof_in;
  logic                 abort;
  logic                 eol;
  logic                 last_line;
  logic                 fval, lval, dval;
  logic                 underrun_d, sof_early_d;
  logic [27:0]          word_d;

  // CameraLink base-configuration bit scatter for ports A/B/C
  function automatic logic [27:0] map_pixel(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c);
    logic [27:0] w;
    w        = '0;
    w[4:0]   = a[4:0];
    w[6]     = a[5];
    w[27]    = a[6];
    w[5]     = a[7];
    w[9:7]   = b[2:0];
    w[14:12] = b[5:3];
    w[11:10] = b[7:6];
    w[15]    = c[0];
    w[22:18] = c[5:1];
    w[17:16] = c[7:6];
    return w;
  endfunction

  assign sof_in        = s_axis.tuser[0];
  assign s_axis.tready = tready_c & ~rst;
  assign beat          = s_axis.tvalid & s_axis.tready;
  assign last_line     = (line_cnt == LAST_LINE);
  // A start of frame on any line but the first means upstream restarted mid-frame
  assign abort         = (state == ST_LINE_WAIT) && (line_cnt != '0) && s_axis.tvalid && sof_in;
  assign eol           = beat && s_axis.tlast && (state == ST_LINE_WAIT || state == ST_LINE);

  always_ff @(posedge cam_clk) begin
    if (rst) begin
      state        <= ST_WAIT_SOF;
      cnt          <= '0;
      line_cnt     <= '0;
      frame_cnt    <= '0;
      cam_data_out <= '0;
      underrun     <= 1'b0;
      sof_early    <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= (state_d != state) ? '0 : cnt + CNT_WIDTH'(1);
      if (state == ST_FV_LEAD && state_d == ST_LINE_WAIT)
        line_cnt <= '0;
      else if (eol && !last_line)
        line_cnt <= line_cnt + CNT_WIDTH'(1);
      if (state == ST_FV_TRAIL && state_d == ST_VBLANK)
        frame_cnt <= frame_cnt + CNT_WIDTH'(1);
      cam_data_out <= word_d;
      underrun     <= underrun_d;
      sof_early    <= sof_early_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_WAIT_SOF:  if (s_axis.tvalid && sof_in) state_d = ST_FV_LEAD;
      ST_FV_LEAD:   if (cnt == LEAD_END) state_d = ST_LINE_WAIT;
      ST_LINE_WAIT: begin
        if (abort)
          state_d = ST_VBLANK;
        else if (eol)
          state_d = last_line ? ST_FV_TRAIL : ST_HBLANK;
        else if (beat)
          state_d = ST_LINE;
      end
      ST_LINE:      if (eol) state_d = last_line ? ST_FV_TRAIL : ST_HBLANK;
      ST_HBLANK:    if (cnt == HB_END) state_d = ST_LINE_WAIT;
      ST_FV_TRAIL:  if (cnt == TRAIL_END) state_d = ST_VBLANK;
      ST_VBLANK:    if (cnt == VB_END) state_d = ST_WAIT_SOF;
      default:      state_d = ST_WAIT_SOF;
    endcase
  end

  always_comb begin
    tready_c    = 1'b0;
    fval        = 1'b0;
    lval        = 1'b0;
    dval        = 1'b0;
    underrun_d  = 1'b0;
    sof_early_d = 1'b0;
    case (state)
      ST_WAIT_SOF: tready_c = s_axis.tvalid & ~sof_in;
      ST_FV_LEAD, ST_HBLANK, ST_FV_TRAIL: fval = 1'b1;
      ST_LINE_WAIT: begin
        fval        = 1'b1;
        tready_c    = ~abort;
        sof_early_d = abort;
        lval        = s_axis.tvalid & ~abort;
        dval        = s_axis.tvalid & ~abort;
      end
      ST_LINE: begin
        fval       = 1'b1;
        lval       = 1'b1;
        tready_c   = 1'b1;
        dval       = s_axis.tvalid;
        underrun_d = ~s_axis.tvalid;
      end
      default: ;
    endcase
    word_d     = dval ? map_pixel(s_axis.tdata[7:0], s_axis.tdata[15:8], s_axis.tdata[23:16])
                      : 28'h0;
    word_d[24] = lval;
    word_d[25] = fval;
    word_d[26] = dval;
  end

endmodule

// File: tb/tb_cam_tx_axis.sv
// tb/tb_cam_tx_axis.sv - directed self-checking bench for cam_tx_axis
module tb_cam_tx_axis;
  localparam logic [27:0] FV = 28'h200_0000;
  localparam logic [27:0] LV = 28'h100_0000;
  localparam logic [27:0] DV = 28'h400_0000;

  logic cam_clk = 1'b0;
  always #5 cam_clk = ~cam_clk;

  logic        rst    = 1'b1;
  logic [23:0] tdata  = '0;
  logic        tvalid = 1'b0;
  logic        tlast  = 1'b0;
  logic        tuser  = 1'b0;
  bit          sel_b  = 1'b0;
  bit          was_rst;

  logic [27:0] word_a, word_b;
  logic        und_a, und_b, sof_a, sof_b;
  logic [15:0] fcnt_a, fcnt_b;

  cam_tx_axis_if #(.DATA_WIDTH(24), .USER_WIDTH(1)) ax_a ();
  cam_tx_axis_if #(.DATA_WIDTH(24), .USER_WIDTH(1)) ax_b ();

  assign ax_a.tdata  = tdata;
  assign ax_a.tvalid = tvalid;
  assign ax_a.tlast  = tlast;
  assign ax_a.tuser  = tuser;
  assign ax_b.tdata  = tdata;
  assign ax_b.tvalid = tvalid;
  assign ax_b.tlast  = tlast;
  assign ax_b.tuser  = tuser;

  cam_tx_axis #(.LINES(2), .HBLANK(2), .VBLANK(3), .FV_LEAD(2), .FV_TRAIL(2)) dut_a (
    .cam_clk(cam_clk), .rst(rst), .s_axis(ax_a), .cam_data_out(word_a),
    .underrun(und_a), .sof_early(sof_a), .frame_cnt(fcnt_a)
  );

  // Same timing but four lines, so an abort lands genuinely mid-frame
  cam_tx_axis #(.LINES(4), .HBLANK(2), .VBLANK(3), .FV_LEAD(2), .FV_TRAIL(2)) dut_b (
    .cam_clk(cam_clk), .rst(rst), .s_axis(ax_b), .cam_data_out(word_b),
    .underrun(und_b), .sof_early(sof_b), .frame_cnt(fcnt_b)
  );

  wire [27:0] word_s   = sel_b ? word_b : word_a;
  wire        und_s    = sel_b ? und_b : und_a;
  wire        sof_s    = sel_b ? sof_b : sof_a;
  wire [15:0] fcnt_s   = sel_b ? fcnt_b : fcnt_a;
  wire        tready_s = sel_b ? ax_b.tready : ax_a.tready;

  logic [29:0] out_q[$];
  logic [29:0] exp_q[$];
  logic [23:0] lp [4];
  int n_chk  = 0;
  int n_pass = 0;

  int pos_a [8] = '{0, 1, 2, 3, 4, 6, 27, 5};
  int pos_b [8] = '{7, 8, 9, 12, 13, 14, 10, 11};
  int pos_c [8] = '{15, 18, 19, 20, 21, 22, 16, 17};

  always @(posedge cam_clk) begin
    was_rst = rst;
    #2;
    if (!was_rst) out_q.push_back({sof_s, und_s, word_s});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [27:0] model_pix(input logic [23:0] d);
    logic [27:0] w = '0;
    for (int i = 0; i < 8; i++) begin
      w[pos_a[i]] = d[i];
      w[pos_b[i]] = d[8+i];
      w[pos_c[i]] = d[16+i];
    end
    return w;
  endfunction

  function automatic void e_rep(input logic [27:0] w, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({2'b00, w});
  endfunction

  function automatic void e_pix(input logic [23:0] d);
    exp_q.push_back({2'b00, FV | LV | DV | model_pix(d)});
  endfunction

  function automatic void e_line();
    for (int i = 0; i < 4; i++) e_pix(lp[i]);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(posedge cam_clk); #1; end
  endtask

  task automatic send_beat(input logic [23:0] d, input bit last, input bit user, input int gap);
    bit acc = 1'b0;
    int k = 0;
    tvalid = 1'b0;
    idle(gap);
    tdata = d; tlast = last; tuser = user; tvalid = 1'b1;
    while (!acc && k < 100) begin
      @(negedge cam_clk);
      acc = tvalid & tready_s;
      @(posedge cam_clk); #1;
      k++;
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0;
    chk("accept", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_line(input bit sof, input int gap_at, input int gap_len);
    for (int i = 0; i < 4; i++)
      send_beat(lp[i], i == 3, sof && i == 0, (i == gap_at) ? gap_len : 0);
  endtask

  task automatic pulse_reset(input int n, input bit busy);
    rst = 1'b1; tvalid = busy; tuser = 1'b0; tlast = 1'b0; tdata = 24'h5A5A5A;
    @(negedge cam_clk);
    chk("rst_tready", {31'd0, tready_s}, 32'd0);
    idle(n);
    chk("rst_word", {4'd0, word_s}, 32'd0);
    chk("rst_underrun", {31'd0, und_s}, 32'd0);
    chk("rst_sof_early", {31'd0, sof_s}, 32'd0);
    chk("rst_frame_cnt", {16'd0, fcnt_s}, 32'd0);
    rst = 1'b0; tvalid = 1'b0;
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic cmp_seq(input string tag);
    chk({tag, "_len"}, {31'd0, out_q.size() >= exp_q.size()}, 32'd1);
    for (int i = 0; i < exp_q.size(); i++)
      if (i < out_q.size()) chk($sformatf("%s_tok%0d", tag, i), {2'd0, out_q[i]}, {2'd0, exp_q[i]});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(posedge cam_clk); #1;

    // full 2x4 frame with continuous data; second pixel is the mapping vector
    sel_b = 1'b0;
    pulse_reset(2, 1'b1);
    e_rep(28'h0, 1); e_rep(FV, 2);
    lp = '{24'hA5C3F0, 24'h408001, 24'h123456, 24'hFFFFFF};
    send_line(1'b1, -1, 0); e_line();
    e_rep(FV, 2);
    lp = '{24'h0F1E2D, 24'h807F01, 24'h55AA33, 24'h000000};
    send_line(1'b0, -1, 0); e_line();
    e_rep(FV, 2); e_rep(28'h0, 3);
    idle(10);
    cmp_seq("frame");
    chk("map_408001", {4'd0, (out_q.size() > 4) ? out_q[4][27:0] : 28'h0}, 32'h7010801);
    chk("frame_cnt_1", {16'd0, fcnt_s}, 32'd1);

    // non-SoF beats are swallowed before the frame starts
    pulse_reset(2, 1'b0);
    send_beat(24'h111111, 1'b0, 1'b0, 0);
    send_beat(24'h222222, 1'b1, 1'b0, 0);
    send_beat(24'h333333, 1'b0, 1'b0, 0);
    e_rep(28'h0, 4); e_rep(FV, 2);
    lp = '{24'hC0FFEE, 24'h00FF00, 24'hFF0000, 24'h0000FF};
    send_line(1'b1, -1, 0); e_line();
    idle(3);
    cmp_seq("drop");

    // two-cycle stall mid-line
    pulse_reset(2, 1'b0);
    e_rep(28'h0, 1); e_rep(FV, 2);
    lp = '{24'h010203, 24'h040506, 24'h070809, 24'h0A0B0C};
    send_line(1'b1, 2, 2);
    e_pix(lp[0]); e_pix(lp[1]);
    exp_q.push_back({2'b01, FV | LV});
    exp_q.push_back({2'b01, FV | LV});
    e_pix(lp[2]); e_pix(lp[3]);
    e_rep(FV, 2);
    lp = '{24'hFEDCBA, 24'h987654, 24'h3210FE, 24'h7E7E7E};
    send_line(1'b0, -1, 0); e_line();
    e_rep(FV, 2); e_rep(28'h0, 3);
    idle(10);
    cmp_seq("stall");
    chk("frame_cnt_stall", {16'd0, fcnt_s}, 32'd1);

    // SoF on the second line of a four-line frame aborts it
    sel_b = 1'b1;
    pulse_reset(2, 1'b0);
    e_rep(28'h0, 1); e_rep(FV, 2);
    lp = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    send_line(1'b1, -1, 0); e_line();
    e_rep(FV, 2);
    exp_q.push_back({2'b10, FV});
    e_rep(28'h0, 4); e_rep(FV, 2);
    lp = '{24'hDEAD01, 24'hBEEF02, 24'hCAFE03, 24'hF00D04};
    send_line(1'b1, -1, 0); e_line();
    e_rep(FV, 2);
    idle(6);
    cmp_seq("abort");
    chk("frame_cnt_abort", {16'd0, fcnt_s}, 32'd0);

    // reset in the middle of a line
    sel_b = 1'b0;
    pulse_reset(2, 1'b0);
    send_beat(24'h13579B, 1'b0, 1'b1, 0);
    send_beat(24'h2468AC, 1'b0, 1'b0, 0);
    send_beat(24'h369CF2, 1'b0, 1'b0, 0);
    pulse_reset(1, 1'b1);
    send_beat(24'h111111, 1'b0, 1'b0, 0);
    send_beat(24'h222222, 1'b0, 1'b0, 0);
    e_rep(28'h0, 3); e_rep(FV, 2);
    lp = '{24'h0A0A0A, 24'hB0B0B0, 24'h0C0C0C, 24'hD0D0D0};
    send_line(1'b1, -1, 0); e_line();
    e_rep(FV, 2);
    idle(4);
    cmp_seq("midrst");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
